// File: rtl/iir_coef_ctrl.sv
// IIR coefficient controller: shadow/active coefficient banks with a flush/settle
// sequence that holds the filter in reset after every coefficient change.
module iir_coef_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [15:0] A1            = 16'h6473,
  parameter logic [15:0] A2            = 16'h3C38,
  parameter logic [31:0] B0            = 32'h40000000,
  parameter logic [15:0] B1            = 16'h678E,
  parameter logic [15:0] B2            = 16'h4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        commit,
  output logic [31:0] coef_b0,
  output logic [15:0] coef_b1,
  output logic [15:0] coef_b2,
  output logic [15:0] coef_a1,
  output logic [15:0] coef_a2,
  output logic        filt_rst_n,
  output logic        out_valid,
  output logic        busy,
  output logic        cfg_err
);

  localparam logic [7:0] FlushLoad  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StFlush, StSettle, StRun} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        cfg_err_q, cfg_err_d;
  logic        do_commit;

  logic [31:0] sh_b0_q, sh_b0_d, act_b0_q, act_b0_d;
  logic [15:0] sh_b1_q, sh_b1_d, act_b1_q, act_b1_d;
  logic [15:0] sh_b2_q, sh_b2_d, act_b2_q, act_b2_d;
  logic [15:0] sh_a1_q, sh_a1_d, act_a1_q, act_a1_d;
  logic [15:0] sh_a2_q, sh_a2_d, act_a2_q, act_a2_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    do_commit = 1'b0;
    sh_b0_d   = sh_b0_q;
    sh_b1_d   = sh_b1_q;
    sh_b2_d   = sh_b2_q;
    sh_a1_d   = sh_a1_q;
    sh_a2_d   = sh_a2_q;
    act_b0_d  = act_b0_q;
    act_b1_d  = act_b1_q;
    act_b2_d  = act_b2_q;
    act_a1_d  = act_a1_q;
    act_a2_d  = act_a2_q;
    cfg_err_d = cfg_valid && (cfg_addr > 3'd4);

    if (cfg_valid) begin
      case (cfg_addr)
        3'd0:    sh_b0_d = cfg_data;
        3'd1:    sh_b1_d = cfg_data[15:0];
        3'd2:    sh_b2_d = cfg_data[15:0];
        3'd3:    sh_a1_d = cfg_data[15:0];
        3'd4:    sh_a2_d = cfg_data[15:0];
        default: ;
      endcase
    end

    unique case (state_q)
      StFlush: begin
        if (commit) pending_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          // A deferred commit replaces the RUN entry with a fresh flush.
          if (pending_q || commit) do_commit = 1'b1;
          else                     state_d   = StRun;
        end else begin
          if (commit) pending_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRun: begin
        if (commit) do_commit = 1'b1;
      end
      default: begin
        state_d = StFlush;
        cnt_d   = FlushLoad;
      end
    endcase

    if (do_commit) begin
      act_b0_d  = sh_b0_d;
      act_b1_d  = sh_b1_d;
      act_b2_d  = sh_b2_d;
      act_a1_d  = sh_a1_d;
      act_a2_d  = sh_a2_d;
      state_d   = StFlush;
      cnt_d     = FlushLoad;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFlush;
      cnt_q     <= FlushLoad;
      pending_q <= 1'b0;
      cfg_err_q <= 1'b0;
      sh_b0_q   <= B0;
      sh_b1_q   <= B1;
      sh_b2_q   <= B2;
      sh_a1_q   <= A1;
      sh_a2_q   <= A2;
      act_b0_q  <= B0;
      act_b1_q  <= B1;
      act_b2_q  <= B2;
      act_a1_q  <= A1;
      act_a2_q  <= A2;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
      sh_b0_q   <= sh_b0_d;
      sh_b1_q   <= sh_b1_d;
      sh_b2_q   <= sh_b2_d;
      sh_a1_q   <= sh_a1_d;
      sh_a2_q   <= sh_a2_d;
      act_b0_q  <= act_b0_d;
      act_b1_q  <= act_b1_d;
      act_b2_q  <= act_b2_d;
      act_a1_q  <= act_a1_d;
      act_a2_q  <= act_a2_d;
    end
  end

  assign cfg_ready  = 1'b1;
  assign cfg_err    = cfg_err_q;
  assign filt_rst_n = (state_q != StFlush);
  assign out_valid  = (state_q == StRun);
  assign busy       = ~out_valid;
  assign coef_b0    = act_b0_q;
  assign coef_b1    = act_b1_q;
  assign coef_b2    = act_b2_q;
  assign coef_a1    = act_a1_q;
  assign coef_a2    = act_a2_q;

endmodule

// File: doc/iir_coef_ctrl.md
IIR_COEF_CTRL -- requirements
Module: iir_coef_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 4: cycles the filter is held in reset after each coefficient change; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles after flush before filter output is declared valid; legal range 1..255.
REQ-003 Parameters A1, A2, B0, B1, B2, defaults 16'h6473, 16'h3C38, 32'h40000000, 16'h678E, 16'h4000: power-on coefficient values.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 cfg_valid  input  1  coefficient write request.
REQ-007 cfg_ready  output  1  write accepted when cfg_valid && cfg_ready at a rising edge.
REQ-008 cfg_addr  input  3  0=B0, 1=B1, 2=B2, 3=A1, 4=A2, 5..7 invalid.
REQ-009 cfg_data  input  32  write data; B0 uses [31:0], all others use [15:0].
REQ-010 commit  input  1  request to apply the shadow bank to the filter.
REQ-011 coef_b0  output  32; coef_b1, coef_b2, coef_a1, coef_a2  output  16 each: active coefficients driving the filter.
REQ-012 filt_rst_n  output  1  active-low reset to the filter datapath.
REQ-013 out_valid  output  1  filter output trustworthy.
REQ-014 busy  output  1  high whenever state is not RUN.
REQ-015 cfg_err  output  1  one-cycle pulse on an accepted write to an invalid address.

Function
REQ-016 The block SHALL hold two coefficient banks: shadow, written by cfg handshakes, and active, driving the coef_* outputs.
REQ-017 FSM states SHALL be FLUSH, SETTLE and RUN, with one down-counter of 8 bits shared by FLUSH and SETTLE.
REQ-018 FLUSH: filt_rst_n=0; the counter loads FLUSH_CYCLES-1 on entry; at count 0 the FSM SHALL go to SETTLE.
REQ-019 SETTLE: filt_rst_n=1; the counter loads SETTLE_CYCLES-1 on entry; at count 0 the FSM SHALL go to RUN.
REQ-020 RUN: filt_rst_n=1, out_valid=1, busy=0.
REQ-021 cfg_ready SHALL be 1 in all states; shadow writes are never blocked.
REQ-022 An accepted write with cfg_addr 0..4 SHALL update only the addressed shadow register on that edge.
REQ-023 An accepted write with cfg_addr 5..7 SHALL change no register and SHALL drive cfg_err=1 for the following cycle only.
REQ-024 A commit sampled in RUN SHALL, on that edge, copy all shadow registers to active, clear out_valid, and enter FLUSH.
REQ-025 If a write and a commit occur on the same edge, the applied bank SHALL include that write.
REQ-026 A commit sampled in FLUSH or SETTLE SHALL set a pending flag; the flag has no depth, so multiple commits merge into one.
REQ-027 If pending=1 when entering RUN, the block SHALL perform the commit action of REQ-024 on that edge instead of entering RUN, and SHALL clear pending.
REQ-028 Latency SHALL be exactly FLUSH_CYCLES+SETTLE_CYCLES cycles from the commit edge to out_valid=1.
REQ-029 Active coefficients SHALL change only on a commit edge; they are stable throughout FLUSH, SETTLE and RUN.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL load the following values:
- state=FLUSH, counter=FLUSH_CYCLES-1
- shadow and active banks = A1/A2/B0/B1/B2 parameters
- filt_rst_n=0, out_valid=0, busy=1, cfg_err=0, pending=0
REQ-031 Reset asserted mid-sequence SHALL abort it, discarding unapplied shadow contents and any pending commit.
REQ-032 After rst_n returns high, filt_rst_n SHALL rise FLUSH_CYCLES cycles later and out_valid FLUSH_CYCLES+SETTLE_CYCLES cycles later.

Verification
REQ-033 Reset release with defaults -> filt_rst_n low for 4 cycles, out_valid=1 at cycle 12, coef_a1=16'h6473, coef_b0=32'h40000000.
REQ-034 In RUN, write addr 3 = 16'h1234, then commit after 5 idle cycles -> coef_a1 stays 16'h6473 until the commit edge, then becomes 16'h1234; out_valid=0 for 12 cycles; filt_rst_n=0 for 4 cycles.
REQ-035 Write addr 6 -> cfg_err pulses exactly one cycle; all coef_* and shadow registers are unchanged.
REQ-036 Commit in RUN, then a second write plus commit during SETTLE -> a second FLUSH starts on the RUN-entry edge, out_valid never rises between the two sequences, and the second value is applied.
REQ-037 Same-edge write of addr 0 = 32'hDEADBEEF with commit -> coef_b0=32'hDEADBEEF after that edge.
REQ-038 rst_n pulled low during SETTLE after an unapplied shadow write -> all registers return to parameter defaults and the full 12-cycle startup repeats.
